writeback_forward: RTL
======================

# writeback_forward

Final pipeline stage of the MIPS datapath. It registers the execute-stage result or the returning load data and drives the register-file write port. It also sources the single forwarding pair (`fwd_ra`, `fwd_rd`) consumed by the decode-stage operand selector. The stage owns a two-state load FSM: it stalls the pipeline while a load waits on memory, then performs sub-word alignment and extension.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge
- `rst`  input  1  asynchronous, active-high reset
- `ex_valid`  input  1  execute stage presents an instruction this cycle
- `ex_reg_write`  input  1  instruction writes a GPR
- `ex_mem_read`  input  1  instruction is a load
- `ex_rd`  input  5  destination register
- `ex_result`  input  32  ALU result (write data for non-loads)
- `ex_load_type`  input  3  000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; other codes treated as LW
- `ex_addr_lo`  input  2  effective address bits [1:0] of the load
- `mem_rdata`  input  32  data memory read word
- `mem_rvalid`  input  1  `mem_rdata` valid this cycle
- `stall`  output  1  freeze all upstream stages
- `wb_we`  output  1  register-file write enable
- `wb_wa`  output  5  register-file write address
- `wb_wd`  output  32  register-file write data
- `fwd_ra`  output  5  forwarded register number
- `fwd_rd`  output  32  forwarded value

## Operation
- States: IDLE, LOAD_WAIT.
- IDLE, `ex_valid` && !`ex_mem_read`:
  - Capture `ex_rd` and `ex_result`, plus write flag = `ex_reg_write` && (`ex_rd` != 0).
  - Stay in IDLE.
- IDLE, `ex_valid` && `ex_mem_read`:
  - Capture `ex_rd`, `ex_load_type`, `ex_addr_lo` and the write flag.
  - Clear the wb write register (`wb_we`=0); go to LOAD_WAIT.
- IDLE, !`ex_valid`: load a bubble (write flag 0).
- LOAD_WAIT:
  - `stall`=1 for the whole state, including the `mem_rvalid` cycle.
  - `ex_*` inputs are ignored.
  - On `mem_rvalid`: register the aligned data into the wb register with the captured write flag, then go to IDLE.
- Alignment (big-endian):
  - Byte lane is `mem_rdata[31-8*a -: 8]` with a=`ex_addr_lo`.
  - Halfword is `[31:16]` if a[1]=0, else `[15:0]`; a[0] is ignored.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- Outputs:
  - `wb_we` is the registered write flag; `wb_wa`/`wb_wd` are the registered rd/data.
  - `fwd_ra` = `wb_we` ? `wb_wa` : 0.
  - `fwd_rd` = `wb_we` ? `wb_wd` : 0. This guarantees a match on r0 forwards zero.
- `mem_rvalid` in IDLE is ignored.

## Timing
- Reset (async): state IDLE; `stall`, `wb_we`, `wb_wa`, `wb_wd`, `fwd_ra`, `fwd_rd` all 0.
- Non-load: edge after `ex_valid`, wb/fwd outputs show the result; latency 1 cycle, throughput 1 per cycle.
- Load:
  - `stall` rises combinationally from the state register, starting the cycle after capture.
  - Write appears on the edge after the `mem_rvalid` cycle; `stall` falls on that same edge.
  - Minimum visible latency is 2 cycles (`mem_rvalid` the cycle after capture).
- Back-to-back loads: the second load is captured in the first IDLE cycle after return; no lost instruction.
- Reset asserted in LOAD_WAIT: abort to IDLE, no write occurs; a later `mem_rvalid` is ignored.
- `stall` never depends combinationally on `ex_*`.

## Configuration
- `WB_SUBWORD_LOAD_EN` defined: full LB/LH/LBU/LHU/LW alignment and extension as above.
- Not defined:
  - `ex_load_type` and `ex_addr_lo` are ignored and not registered; every load writes `mem_rdata` unchanged.
  - FSM and timing are identical.

## Test plan
- Reset mid-LOAD_WAIT, then `mem_rvalid`=1 → no write; all outputs stay 0; state IDLE.
- ALU op: rd=5, result 0x1234_5678, `ex_reg_write`=1 → next cycle `wb_we`=1, `wb_wa`=5, `fwd_ra`=5, `fwd_rd`=0x1234_5678.
- ALU op with rd=0 → `wb_we`=0, `fwd_ra`=0, `fwd_rd`=0.
- LB at addr_lo=2, `mem_rdata`=0x00_00_80_00, `mem_rvalid` 3 cycles late → `stall`=1 for 4 cycles; then `wb_wd`=0xFFFF_FF80.
- LHU at addr_lo=2, data 0xAAAA_8001 → `wb_wd`=0x0000_8001; LH → 0xFFFF_8001. Without `WB_SUBWORD_LOAD_EN` → 0xAAAA_8001.
- LW immediately followed by an ALU op to rd=7 → ALU op held while stalled, then captured; writes occur in order (load, then rd=7).

Source files
------------

// File: rtl/writeback_forward_if.sv
// rtl/writeback_forward_if.sv - execute/memory inputs and writeback/forward outputs of the writeback stage
// master: upstream pipeline and data memory side (drives ex_*, mem_*)
// slave : writeback_forward (drives stall, wb_*, fwd_*)
interface writeback_forward_if;
    logic        ex_valid;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic [4:0]  ex_rd;
    logic [31:0] ex_result;
    logic [2:0]  ex_load_type;
    logic [1:0]  ex_addr_lo;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        stall;
    logic        wb_we;
    logic [4:0]  wb_wa;
    logic [31:0] wb_wd;
    logic [4:0]  fwd_ra;
    logic [31:0] fwd_rd;

    modport master (
        output ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
               ex_load_type, ex_addr_lo, mem_rdata, mem_rvalid,
        input  stall, wb_we, wb_wa, wb_wd, fwd_ra, fwd_rd
    );

    modport slave (
        input  ex_valid, ex_reg_write, ex_mem_read, ex_rd, ex_result,
               ex_load_type, ex_addr_lo, mem_rdata, mem_rvalid,
        output stall, wb_we, wb_wa, wb_wd, fwd_ra, fwd_rd
    );
endinterface

// File: rtl/writeback_forward.sv
// rtl/writeback_forward.sv - writeback stage with load-wait FSM, sub-word load alignment and r0-safe forwarding
// clk, rst : rising-edge clock, asynchronous active-high reset
// bus      : writeback_forward_if.slave (ex_* / mem_* in; stall, wb_*, fwd_* out)
// WB_SUBWORD_LOAD_EN : when defined, LB/LH/LBU/LHU alignment and extension; otherwise loads write mem_rdata unchanged
module writeback_forward (
    input  logic              clk,
    input  logic              rst,
    writeback_forward_if.slave bus
);

    typedef enum logic {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic        ld_we_q, ld_we_d;
    logic [4:0]  ld_rd_q, ld_rd_d;
    logic [31:0] load_data;
    logic        ex_write;

    // r0 is never written, so a write to it is dropped at capture time.
    assign ex_write = bus.ex_reg_write && (bus.ex_rd != 5'd0);

`ifdef WB_SUBWORD_LOAD_EN
    logic [2:0]  ld_type_q, ld_type_d;
    logic [1:0]  ld_lo_q, ld_lo_d;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Big-endian: address offset 0 is the most significant byte.
    always_comb begin
        byte_lane = 8'h00;
        case (ld_lo_q)
            2'd0:    byte_lane = bus.mem_rdata[31:24];
            2'd1:    byte_lane = bus.mem_rdata[23:16];
            2'd2:    byte_lane = bus.mem_rdata[15:8];
            default: byte_lane = bus.mem_rdata[7:0];
        endcase
        half_lane = ld_lo_q[1] ? bus.mem_rdata[15:0] : bus.mem_rdata[31:16];
        load_data = bus.mem_rdata;
        case (ld_type_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b100:  load_data = {24'h000000, byte_lane};
            3'b101:  load_data = {16'h0000, half_lane};
            default: load_data = bus.mem_rdata;
        endcase
    end
`else
    assign load_data = bus.mem_rdata;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            we_q      <= 1'b0;
            wa_q      <= 5'd0;
            wd_q      <= 32'd0;
            ld_we_q   <= 1'b0;
            ld_rd_q   <= 5'd0;
`ifdef WB_SUBWORD_LOAD_EN
            ld_type_q <= 3'd0;
            ld_lo_q   <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            we_q      <= we_d;
            wa_q      <= wa_d;
            wd_q      <= wd_d;
            ld_we_q   <= ld_we_d;
            ld_rd_q   <= ld_rd_d;
`ifdef WB_SUBWORD_LOAD_EN
            ld_type_q <= ld_type_d;
            ld_lo_q   <= ld_lo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        wa_d      = wa_q;
        wd_d      = wd_q;
        ld_we_d   = ld_we_q;
        ld_rd_d   = ld_rd_q;
`ifdef WB_SUBWORD_LOAD_EN
        ld_type_d = ld_type_q;
        ld_lo_d   = ld_lo_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.ex_valid && bus.ex_mem_read) begin
                    ld_we_d   = ex_write;
                    ld_rd_d   = bus.ex_rd;
`ifdef WB_SUBWORD_LOAD_EN
                    ld_type_d = bus.ex_load_type;
                    ld_lo_d   = bus.ex_addr_lo;
`endif
                    we_d      = 1'b0;
                    state_d   = LOAD_WAIT;
                end else if (bus.ex_valid) begin
                    we_d = ex_write;
                    wa_d = bus.ex_rd;
                    wd_d = bus.ex_result;
                end else begin
                    we_d = 1'b0;
                end
            end
            LOAD_WAIT: begin
                // Upstream is frozen here, so ex_* carries nothing new.
                if (bus.mem_rvalid) begin
                    we_d    = ld_we_q;
                    wa_d    = ld_rd_q;
                    wd_d    = load_data;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall is a pure function of the state register, never of ex_*.
    assign bus.stall  = (state_q == LOAD_WAIT);
    assign bus.wb_we  = we_q;
    assign bus.wb_wa  = wa_q;
    assign bus.wb_wd  = wd_q;
    // Masking with wb_we keeps a decode-stage match on r0 from picking up stale data.
    assign bus.fwd_ra = we_q ? wa_q : 5'd0;
    assign bus.fwd_rd = we_q ? wd_q : 32'd0;

endmodule
